// File: rtl/ssd_scan_controller_if.sv
// ssd_scan_controller_if: value handshake from the measurement logic into the display controller
interface ssd_scan_controller_if #(
   parameter int VAL_W = 14
);
   logic [VAL_W-1:0] value_in;
   logic             value_valid;
   logic             value_ready;
   modport master (output value_in, value_valid, input value_ready);
   modport slave (input value_in, value_valid, output value_ready);
endinterface

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: binary-to-BCD via shift-and-add-3, atomic display register, multiplexed 4-digit scan
module seven_segment_digit (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   always_comb
      case (digit)
         4'd0: seg = 7'h3f;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5b;
         4'd3: seg = 7'h4f;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6d;
         4'd6: seg = 7'h7d;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7f;
         4'd9: seg = 7'h6f;
         default: seg = 7'h00;
      endcase
endmodule

module ssd_scan_controller #(
   parameter int SCAN_DIV = 50000,
   parameter int VAL_W    = 14
) (
   input  logic                  clk,
   input  logic                  reset_n,
   ssd_scan_controller_if.slave  bus,
   input  logic                  blank_lz,
   output logic [6:0]            seg_out,
   output logic [3:0]            dig_en,
   output logic                  update_done
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t state, state_nx;
   logic [VAL_W-1:0] bin, clipped;
   logic [15:0] bcd, bcd_adj, disp;
   logic [4:0] cnt;
   logic [PW-1:0] presc;
   logic [1:0] idx;
   logic [3:0] digit;
   logic last_iter, wrap, z1, z2, z3, blanked;
   assign clipped   = bus.value_in > VAL_W'(9999) ? VAL_W'(9999) : bus.value_in;
   assign last_iter = cnt == 5'(VAL_W - 1);
   assign wrap      = presc == PW'(SCAN_DIV - 1);
   for (genvar i = 0; i < 4; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE  ? (bus.value_valid ? SHIFT : IDLE) :
                 state == SHIFT ? (last_iter ? COMMIT : SHIFT) : IDLE;
   always_comb
      bus.value_ready = state == IDLE;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bin         <= '0;
         bcd         <= '0;
         cnt         <= '0;
         disp        <= '0;
         update_done <= 1'b0;
      end else begin
         update_done <= state == COMMIT;
         if (state == IDLE && bus.value_valid) begin
            bin <= clipped;
            bcd <= '0;
            cnt <= '0;
         end else if (state == SHIFT) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            cnt        <= cnt + 5'd1;
         end
         if (state == COMMIT) disp <= bcd;
      end
   // free-running scan, deliberately decoupled from the conversion FSM
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         idx   <= idx + {1'b0, wrap};
      end
   assign digit   = disp[{idx, 2'b00} +: 4];
   assign z3      = disp[15:12] == 4'd0;
   assign z2      = z3 && disp[11:8] == 4'd0;
   assign z1      = z2 && disp[7:4] == 4'd0;
   assign blanked = blank_lz && (idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0);
   assign dig_en  = blanked ? 4'b0000 : 4'b0001 << idx;
   seven_segment_digit u_dec (.digit(digit), .seg(seg_out));
endmodule
